// File: rtl/interrupt_controller.sv
// Game Boy interrupt controller: IF/IE registers, request collection, priority
// encoding and a short sequencer that fetches the dispatch vector from the table.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for int_ack with an enabled interrupt pending
// ADDR_LO | table index 2n presented, move index to 2n+1
// CAP_LO  | table_do holds the low vector byte
// CAP_HI  | table_do holds the high vector byte, vector registered
// DONE    | vector_valid strobe cycle, then back to IDLE
module interrupt_controller (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [4:0]  irq_in,
  input  logic [15:0] A,
  input  logic [7:0]  Di,
  output logic [7:0]  Do,
  input  logic        wr,
  input  logic        rd,
  input  logic        ime,
  input  logic        int_ack,
  output logic        int_req,
  output logic        int_pending,
  output logic [3:0]  table_addr,
  input  logic [7:0]  table_do,
  output logic [15:0] vector,
  output logic        vector_valid
);

  localparam logic [15:0] ADDR_IF = 16'hFF0F;
  localparam logic [15:0] ADDR_IE = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR_LO = 3'd1,
    CAP_LO  = 3'd2,
    CAP_HI  = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t      state;
  logic [4:0]  if_q;
  logic [7:0]  ie_q;
  logic [2:0]  irq_n;
  logic [7:0]  vec_lo;

  logic [4:0]  pend;
  logic        pend_any;
  logic [2:0]  pend_idx;
  logic        ack_take;
  logic [4:0]  if_nxt;

  // Lowest-numbered enabled request wins.
  always_comb begin
    pend     = ie_q[4:0] & if_q;
    pend_any = |pend;
    pend_idx = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (pend[i]) pend_idx = 3'(i);
    end
  end

  assign ack_take = (state == IDLE) && int_ack && pend_any;

  // Per-bit precedence: ack clear, then CPU write, then incoming request.
  always_comb begin
    if_nxt = if_q;
    if (ack_take) if_nxt[pend_idx] = 1'b0;
    if (wr && (A == ADDR_IF)) if_nxt = Di[4:0];
    if_nxt = if_nxt | irq_in;
  end

  assign int_pending = pend_any;
  assign int_req     = pend_any && ime && (state == IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      if_q <= 5'd0;
      ie_q <= 8'd0;
      Do   <= 8'd0;
    end else begin
      if_q <= if_nxt;
      if (wr && (A == ADDR_IE)) ie_q <= Di;
      if (rd) begin
        case (A)
          ADDR_IF: Do <= {3'b111, if_q};
          ADDR_IE: Do <= ie_q;
          default: Do <= 8'h00;
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      irq_n        <= 3'd0;
      table_addr   <= 4'd0;
      vec_lo       <= 8'd0;
      vector       <= 16'd0;
      vector_valid <= 1'b0;
    end else begin
      vector_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (ack_take) begin
            irq_n      <= pend_idx;
            table_addr <= {pend_idx, 1'b0};
            state      <= ADDR_LO;
          end
        end
        ADDR_LO: begin
          table_addr <= {irq_n, 1'b1};
          state      <= CAP_LO;
        end
        CAP_LO: begin
          vec_lo <= table_do;
          state  <= CAP_HI;
        end
        CAP_HI: begin
          vector       <= {table_do, vec_lo};
          vector_valid <= 1'b1;
          state        <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Scoreboard bench for interrupt_controller: stimulus pushes expected vectors and
// register reads; monitors pop and compare when the DUT presents them.
module tb_interrupt_controller;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [4:0]  irq_in;
  logic [15:0] A;
  logic [7:0]  Di;
  logic [7:0]  Do;
  logic        wr, rd, ime, int_ack;
  logic        int_req, int_pending;
  logic [3:0]  table_addr;
  logic [7:0]  table_do;
  logic [15:0] vector;
  logic        vector_valid;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [15:0] vec;
    int          due;
  } vexp_t;

  vexp_t      vq[$];
  logic [7:0] rq[$];
  logic [7:0] rom [16];
  logic       rd_s = 1'b0;

  interrupt_controller dut (
    .clock(clock), .reset_n(reset_n), .irq_in(irq_in), .A(A), .Di(Di), .Do(Do),
    .wr(wr), .rd(rd), .ime(ime), .int_ack(int_ack), .int_req(int_req),
    .int_pending(int_pending), .table_addr(table_addr), .table_do(table_do),
    .vector(vector), .vector_valid(vector_valid)
  );

  always #5 clock = ~clock;

  // Registered vector table: entry n is 0x0040 + 8n, stored little-endian.
  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 8'hEE;
    for (int n = 0; n < 5; n++) begin
      rom[2*n]   = 8'(8'h40 + 8*n);
      rom[2*n+1] = 8'h00;
    end
  end

  always @(posedge clock) begin
    table_do <= rom[table_addr];
    cyc      <= cyc + 1;
    rd_s     <= rd && reset_n;
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Vector monitor: every strobe must match the oldest expected dispatch in value and cycle.
  always @(negedge clock) begin
    if (vq.size() > 0 && vq[0].due < cyc) begin
      vexp_t m;
      m = vq.pop_front();
      checks++; failures++;
      $display("FAIL vector_missing: no vector_valid for %h due cycle %0d", m.vec, m.due);
    end
    if (vector_valid) begin
      if (vq.size() == 0) begin
        checks++; failures++;
        $display("FAIL vector_unexpected: got %h expected no strobe (cycle %0d)", vector, cyc);
      end else begin
        vexp_t e;
        e = vq.pop_front();
        chk("vector_value", vector, e.vec);
        chk("vector_cycle", 16'(cyc), 16'(e.due));
      end
    end
  end

  // Read monitor: Do is compared the cycle after rd was sampled.
  always @(negedge clock) begin
    if (rd_s) begin
      if (rq.size() == 0) begin
        checks++; failures++;
        $display("FAIL read_unexpected: got %h expected no read", Do);
      end else begin
        logic [7:0] e;
        e = rq.pop_front();
        chk("reg_read", 16'(Do), 16'(e));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic write_reg(input logic [15:0] addr, input logic [7:0] data);
    A = addr; Di = data; wr = 1'b1;
    tick();
    wr = 1'b0;
  endtask

  task automatic read_reg(input logic [15:0] addr, input logic [7:0] exp);
    A = addr; rd = 1'b1;
    rq.push_back(exp);
    tick();
    rd = 1'b0;
  endtask

  task automatic pulse_irq(input logic [4:0] bits);
    irq_in = bits;
    tick();
    irq_in = 5'd0;
  endtask

  // Ack is sampled at the next edge k; the strobe belongs to the cycle after k+3.
  task automatic ack(input logic expect_dispatch, input logic [15:0] vec);
    vexp_t e;
    if (expect_dispatch) begin
      e.vec = vec;
      e.due = cyc + 4;
      vq.push_back(e);
    end
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; irq_in = 5'd0; A = 16'h0000; Di = 8'h00;
    wr = 1'b0; rd = 1'b0; ime = 1'b0; int_ack = 1'b0;
    ticks(2);
    chk("rst_do", 16'(Do), 16'h0);
    chk("rst_table_addr", 16'(table_addr), 16'h0);
    chk("rst_vector", vector, 16'h0);
    chk("rst_vector_valid", 16'(vector_valid), 16'h0);
    chk("rst_int_req", 16'(int_req), 16'h0);
    chk("rst_int_pending", 16'(int_pending), 16'h0);
    reset_n = 1'b1;
    tick();

    // V-Blank dispatch
    write_reg(16'hFFFF, 8'h01);
    ime = 1'b1;
    pulse_irq(5'b00001);
    chk("vblank_int_req", 16'(int_req), 16'h1);
    ack(1'b1, 16'h0040);
    chk("vblank_addr_lo", 16'(table_addr), 16'h0);
    chk("vblank_req_busy", 16'(int_req), 16'h0);
    tick();
    chk("vblank_addr_hi", 16'(table_addr), 16'h1);
    ticks(3);
    read_reg(16'hFF0F, 8'hE0);

    // Timer and Serial together: Timer first
    write_reg(16'hFFFF, 8'h1F);
    pulse_irq(5'b01100);
    ack(1'b1, 16'h0050);
    chk("timer_addr", 16'(table_addr), 16'h4);
    ticks(4);
    read_reg(16'hFF0F, 8'hE8);
    ack(1'b1, 16'h0058);
    chk("serial_addr", 16'(table_addr), 16'h6);
    ticks(4);
    read_reg(16'hFF0F, 8'hE0);

    // Joypad gated by ime
    ime = 1'b0;
    write_reg(16'hFFFF, 8'h10);
    pulse_irq(5'b10000);
    chk("joy_pending", 16'(int_pending), 16'h1);
    chk("joy_req_ime0", 16'(int_req), 16'h0);
    ime = 1'b1;
    #1;
    chk("joy_req_ime1", 16'(int_req), 16'h1);
    ack(1'b1, 16'h0060);
    ticks(4);

    // IF write loses to a same-cycle request; IE and unmapped reads
    irq_in = 5'b00010;
    write_reg(16'hFF0F, 8'h00);
    irq_in = 5'd0;
    read_reg(16'hFF0F, 8'hE2);
    write_reg(16'hFFFF, 8'hA5);
    read_reg(16'hFFFF, 8'hA5);
    tick();
    chk("do_hold", 16'(Do), 16'hA5);
    read_reg(16'h1234, 8'h00);

    // LCD STAT ack aborted by reset two cycles later
    write_reg(16'hFFFF, 8'h02);
    ack(1'b0, 16'h0000);
    ticks(2);
    reset_n = 1'b0;
    #1;
    chk("abort_table_addr", 16'(table_addr), 16'h0);
    chk("abort_vector", vector, 16'h0);
    chk("abort_do", 16'(Do), 16'h0);
    chk("abort_int_pending", 16'(int_pending), 16'h0);
    tick();
    reset_n = 1'b1;
    ticks(5);
    read_reg(16'hFF0F, 8'hE0);

    // Ack with nothing enabled is ignored and leaves IF intact
    pulse_irq(5'b00100);
    ack(1'b0, 16'h0000);
    chk("idle_ack_table_addr", 16'(table_addr), 16'h0);
    ticks(5);
    read_reg(16'hFF0F, 8'hE4);

    // Second ack during CAP_LO is ignored
    write_reg(16'hFFFF, 8'h05);
    pulse_irq(5'b00001);
    ack(1'b1, 16'h0040);
    tick();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    ticks(3);
    read_reg(16'hFF0F, 8'hE4);
    ack(1'b1, 16'h0050);
    ticks(6);

    if (vq.size() != 0) begin
      checks++; failures++;
      $display("FAIL vector_queue: %0d dispatches outstanding, expected 0", vq.size());
    end
    if (rq.size() != 0) begin
      checks++; failures++;
      $display("FAIL read_queue: %0d reads outstanding, expected 0", rq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
